// File: rtl/launchpad_pkg.sv
// Shared types and width helpers for the launchpad keypad scanner.
// Events are packed as {pressed, row, col}.
package launchpad_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        EVAL   = 1'b1
    } scan_state_t;

    function automatic int row_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int evt_w(input int rows, input int cols);
        return 1 + row_w(rows) + $clog2(cols);
    endfunction

endpackage

// File: rtl/launchpad_event_fifo.sv
// Show-ahead event FIFO with registered head and drop-on-full.
// Fullness is judged before any same-cycle pop.
module launchpad_event_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             drop,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    rptr_n;
    logic [CW-1:0]    count;
    logic [CW-1:0]    left;
    logic             full;
    logic             empty;
    logic             wr;
    logic             rd;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign wr     = push && !full;
    assign rd     = pop && !empty;
    assign drop   = push && full;
    assign rptr_n = rptr + AW'(rd);
    assign left   = count - CW'(rd);

    always_ff @(posedge clk) begin
        if (wr)
            mem[wptr] <= din;
    end

    // Head register is reloaded with whatever will sit at the read pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            valid <= 1'b0;
            dout  <= '0;
        end else begin
            if (wr)
                wptr <= wptr + AW'(1);
            rptr  <= rptr_n;
            count <= left + CW'(wr);
            valid <= (left != '0) || wr;
            if (left != '0)
                dout <= mem[rptr_n];
            else if (wr)
                dout <= din;
        end
    end

endmodule

// File: rtl/launchpad_scanner.sv
// Keypad matrix scanner: column drive, row sync, per-key debounce,
// debounced key bitmap and press/release event queue.
module launchpad_scanner
    import launchpad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic [COLS-1:0]          col_drive,
    input  logic [ROWS-1:0]          row_sense,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic                     evt_pressed,
    output logic [row_w(ROWS)-1:0]   evt_row,
    output logic [$clog2(COLS)-1:0]  evt_col,
    output logic [ROWS*COLS-1:0]     key_state,
    output logic [$clog2(COLS)-1:0]  scan_col,
    output logic                     overflow,
    input  logic                     clear_overflow
);

    localparam int ROW_W = row_w(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int NKEYS = ROWS * COLS;
    localparam int KW    = $clog2(NKEYS);
    localparam int DW    = $clog2(DEBOUNCE_SCANS + 1);
    localparam int SW    = $clog2(SETTLE_CYCLES);
    localparam int EW    = evt_w(ROWS, COLS);

    logic [ROWS-1:0]  sync1;
    logic [ROWS-1:0]  sync2;
    scan_state_t      state;
    logic [SW-1:0]    settle_cnt;
    logic [ROW_W-1:0] row;
    logic [DW-1:0]    dcnt [NKEYS];
    logic [KW-1:0]    kidx;
    logic [DW-1:0]    cur_cnt;
    logic             sample;
    logic             differ;
    logic             flip;
    logic [EW-1:0]    evt_din;
    logic [EW-1:0]    evt_dout;
    logic             fifo_drop;

    assign kidx      = KW'(int'(row) * COLS + int'(scan_col));
    assign sample    = sync2[row];
    assign cur_cnt   = dcnt[kidx];
    assign differ    = (state == EVAL) && (sample != key_state[kidx]);
    assign flip      = differ && (cur_cnt == DW'(DEBOUNCE_SCANS - 1));
    assign evt_din   = {sample, row, scan_col};
    assign col_drive = ~(COLS'(1) << scan_col);

    assign {evt_pressed, evt_row, evt_col} = evt_dout;

    // Rows are inverted on entry so 1 means the switch is closed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '0;
            sync2      <= '0;
            state      <= SETTLE;
            settle_cnt <= '0;
            row        <= '0;
            scan_col   <= '0;
            key_state  <= '0;
            overflow   <= 1'b0;
            for (int i = 0; i < NKEYS; i++)
                dcnt[i] <= '0;
        end else begin
            sync1 <= ~row_sense;
            sync2 <= sync1;

            if (fifo_drop)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;

            unique case (state)
                SETTLE: begin
                    if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                        settle_cnt <= '0;
                        row        <= '0;
                        state      <= EVAL;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                EVAL: begin
                    if (flip) begin
                        key_state[kidx] <= sample;
                        dcnt[kidx]      <= '0;
                    end else if (differ) begin
                        dcnt[kidx] <= cur_cnt + DW'(1);
                    end else begin
                        dcnt[kidx] <= '0;
                    end

                    if (row == ROW_W'(ROWS - 1)) begin
                        state <= SETTLE;
                        if (scan_col == COL_W'(COLS - 1))
                            scan_col <= '0;
                        else
                            scan_col <= scan_col + COL_W'(1);
                    end else begin
                        row <= row + ROW_W'(1);
                    end
                end
                default: state <= SETTLE;
            endcase
        end
    end

    launchpad_event_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (flip),
        .din   (evt_din),
        .pop   (evt_valid && evt_ready),
        .drop  (fifo_drop),
        .valid (evt_valid),
        .dout  (evt_dout)
    );

endmodule

// File: tb/tb_launchpad_scanner.sv
// Directed bench for launchpad_scanner at default parameters.
// A small switch-matrix model closes row lines for the driven column.
module tb_launchpad_scanner;

    logic        clk;
    logic        reset_n;
    logic [3:0]  col_drive;
    logic [3:0]  row_sense;
    logic        evt_valid;
    logic        evt_ready;
    logic        evt_pressed;
    logic [1:0]  evt_row;
    logic [1:0]  evt_col;
    logic [15:0] key_state;
    logic [1:0]  scan_col;
    logic        overflow;
    logic        clear_overflow;

    logic [3:0]  key_mat [4];
    logic [4:0]  evq [$];
    int          cycq [$];
    int          cyc;
    int          nvec;
    int          nerr;

    typedef struct {
        int          wait_cyc;
        logic [1:0]  scol;
        logic [3:0]  cdrv;
        logic [15:0] ks;
    } vec_t;

    vec_t tbl [6];

    launchpad_scanner dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .col_drive      (col_drive),
        .row_sense      (row_sense),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_pressed    (evt_pressed),
        .evt_row        (evt_row),
        .evt_col        (evt_col),
        .key_state      (key_state),
        .scan_col       (scan_col),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Physical matrix: a closed key pulls its row low when its column is driven.
    always_comb begin
        row_sense = '1;
        for (int r = 0; r < 4; r++)
            row_sense[r] = ~|(key_mat[r] & ~col_drive);
    end

    always @(negedge clk) begin
        if (reset_n && evt_valid && evt_ready) begin
            evq.push_back({evt_pressed, evt_row, evt_col});
            cycq.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] ev_at(input int i);
        if (i < evq.size())
            return evq[i];
        return 5'bx;
    endfunction

    task automatic align_col0();
        logic [1:0] prev;
        logic       found;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            prev = scan_col;
            tick();
            if (prev == 2'd3 && scan_col == 2'd0)
                found = 1'b1;
        end
        chk("align_col0", {31'b0, found}, 32'd1);
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++)
            key_mat[r] = 4'b0000;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        cyc  = 0;
        reset_n        = 1'b0;
        evt_ready      = 1'b1;
        clear_overflow = 1'b0;
        clear_keys();

        tbl[0] = '{7, 2'd0, 4'b1110, 16'h0000};
        tbl[1] = '{1, 2'd1, 4'b1101, 16'h0000};
        tbl[2] = '{7, 2'd1, 4'b1101, 16'h0000};
        tbl[3] = '{1, 2'd2, 4'b1011, 16'h0000};
        tbl[4] = '{8, 2'd3, 4'b0111, 16'h0000};
        tbl[5] = '{8, 2'd0, 4'b1110, 16'h0000};

        // Reset state
        repeat (3) tick();
        chk("rst_col_drive", {28'b0, col_drive}, 32'hE);
        chk("rst_evt_valid", {31'b0, evt_valid}, 32'd0);
        chk("rst_key_state", {16'b0, key_state}, 32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);

        // Column stepping after reset release
        reset_n = 1'b1;
        foreach (tbl[i]) begin
            repeat (tbl[i].wait_cyc) tick();
            chk($sformatf("scan_col[%0d]", i),
                {30'b0, scan_col}, {30'b0, tbl[i].scol});
            chk($sformatf("col_drive[%0d]", i),
                {28'b0, col_drive}, {28'b0, tbl[i].cdrv});
            chk($sformatf("key_state[%0d]", i),
                {16'b0, key_state}, {16'b0, tbl[i].ks});
        end

        // Single key press then release
        evq.delete();
        cycq.delete();
        key_mat[2][1] = 1'b1;
        repeat (160) tick();
        chk("single_press_cnt", evq.size(), 32'd1);
        chk("single_press_evt", {27'b0, ev_at(0)}, {27'b0, 5'b1_10_01});
        chk("single_press_ks", {16'b0, key_state}, 32'h0200);

        evq.delete();
        cycq.delete();
        key_mat[2][1] = 1'b0;
        repeat (160) tick();
        chk("single_rel_cnt", evq.size(), 32'd1);
        chk("single_rel_evt", {27'b0, ev_at(0)}, {27'b0, 5'b0_10_01});
        chk("single_rel_ks", {16'b0, key_state}, 32'h0000);

        // Bounce: alternate samples never reach the debounce threshold
        evq.delete();
        cycq.delete();
        for (int s = 0; s < 10; s++) begin
            key_mat[0][0] = (s % 2 == 0);
            repeat (32) tick();
        end
        key_mat[0][0] = 1'b0;
        repeat (64) tick();
        chk("bounce_cnt", evq.size(), 32'd0);
        chk("bounce_ks", {16'b0, key_state}, 32'h0000);

        // Two keys in the same column change together
        evq.delete();
        cycq.delete();
        key_mat[0][3] = 1'b1;
        key_mat[3][3] = 1'b1;
        repeat (160) tick();
        chk("simul_cnt", evq.size(), 32'd2);
        chk("simul_evt0", {27'b0, ev_at(0)}, {27'b0, 5'b1_00_11});
        chk("simul_evt1", {27'b0, ev_at(1)}, {27'b0, 5'b1_11_11});
        chk("simul_gap",
            (cycq.size() > 1) ? cycq[1] - cycq[0] : -1, 32'd3);
        chk("simul_ks", {16'b0, key_state}, 32'h8008);

        // Overflow: six events into a four-entry queue
        evt_ready = 1'b0;
        align_col0();
        key_mat[1][0] = 1'b1;
        key_mat[0][1] = 1'b1;
        key_mat[2][2] = 1'b1;
        key_mat[3][2] = 1'b1;
        key_mat[0][3] = 1'b0;
        key_mat[3][3] = 1'b0;
        repeat (128) tick();
        chk("ovf_valid", {31'b0, evt_valid}, 32'd1);
        chk("ovf_head", {27'b0, evt_pressed, evt_row, evt_col},
            {27'b0, 5'b1_01_00});
        chk("ovf_flag", {31'b0, overflow}, 32'd1);
        chk("ovf_ks", {16'b0, key_state}, 32'h4412);

        evq.delete();
        cycq.delete();
        evt_ready = 1'b1;
        repeat (8) tick();
        chk("drain_cnt", evq.size(), 32'd4);
        chk("drain_evt0", {27'b0, ev_at(0)}, {27'b0, 5'b1_01_00});
        chk("drain_evt1", {27'b0, ev_at(1)}, {27'b0, 5'b1_00_01});
        chk("drain_evt2", {27'b0, ev_at(2)}, {27'b0, 5'b1_10_10});
        chk("drain_evt3", {27'b0, ev_at(3)}, {27'b0, 5'b1_11_10});
        chk("drain_valid", {31'b0, evt_valid}, 32'd0);
        chk("ovf_sticky", {31'b0, overflow}, 32'd1);

        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("ovf_cleared", {31'b0, overflow}, 32'd0);

        // Reset with a key held and two events queued
        evt_ready = 1'b0;
        align_col0();
        key_mat[1][1] = 1'b1;
        key_mat[1][0] = 1'b0;
        repeat (128) tick();
        chk("mid_valid", {31'b0, evt_valid}, 32'd1);
        chk("mid_head", {27'b0, evt_pressed, evt_row, evt_col},
            {27'b0, 5'b0_01_00});

        reset_n = 1'b0;
        clear_keys();
        key_mat[1][1] = 1'b1;
        tick();
        chk("mid_rst_valid", {31'b0, evt_valid}, 32'd0);
        chk("mid_rst_ks", {16'b0, key_state}, 32'd0);
        chk("mid_rst_col", {30'b0, scan_col}, 32'd0);
        tick();
        evq.delete();
        cycq.delete();
        evt_ready = 1'b1;
        reset_n   = 1'b1;
        repeat (128) tick();
        chk("rereport_cnt", evq.size(), 32'd1);
        chk("rereport_evt", {27'b0, ev_at(0)}, {27'b0, 5'b1_01_01});
        chk("rereport_ks", {16'b0, key_state}, 32'h0020);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
